// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// Combinational 1-bit full-adder cell, time-shared across all bit positions.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB-first through
// one full-adder cell, one bit per clock, with a start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a-b.
import serial_adder_pkg::*;

module serial_adder_ctrl #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sha, shb, res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             accept, last_bit;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  // Subtraction is a + ~b + 1; cin is ignored while subtracting.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b   : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  fa_bit u_fa (
    .a   (sha[0]),
    .b   (shb[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_bit  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand shifters, carry, counter; result captured on the last bit so
  // sum/cout are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sha   <= '0;
      shb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      sha   <= a;
      shb   <= b_ld;
      res   <= '0;
      carry <= c_ld;
      cnt   <= '0;
    end else if (busy) begin
      sha   <= sha >> 1;
      shb   <= shb >> 1;
      res   <= {fa_s, res[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        sum  <= {fa_s, res[WIDTH-1:1]};
        cout <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected
// {cout,sum} at acceptance, a monitor pops and compares on every done.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int npass = 0;
  int ntot  = 0;
  int ndone = 0;
  int nacc  = 0;
  logic [W:0] q[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      ndone++;
      if (q.size() == 0) begin
        ntot++;
        $display("FAIL spurious_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        logic [W:0] e;
        e = q.pop_front();
        chk("cout_sum", {23'd0, cout, sum}, {23'd0, e});
      end
    end
  end

  // Issue one operation; poke>0 re-asserts start (a=b=1) in that run cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input logic [W:0] exp, input int poke, input bit timing);
    int  n, nbusy;
    bit  seen;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    q.push_back(exp);
    nacc++;
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    n = 0; nbusy = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (poke > 0 && n == poke) begin start = 1'b1; a = 8'h01; b = 8'h01; end
      if (poke > 0 && n == poke + 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    if (!seen) begin
      ntot++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end else if (timing) begin
      chk("latency", n, W + 1);
      chk("busy_cycles", nbusy, W);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
`ifdef SERIAL_ADDER_SUB_EN
    if (ms) return {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
`endif
    return {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
  endfunction

  initial begin
    int nd;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, 1'b0, 9'h07F, 0, 1);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 0, 1);
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 9'h001, 0, 1);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 9'h030, 3, 1);
    chk("held_sum", sum, 8'h30);

    // Reset in run cycle 4 aborts with zeroed outputs and no done.
    @(negedge clk);
    a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    rst = 1'b0;
    nd = ndone;
    repeat (15) @(negedge clk);
    chk("abort_no_done", ndone - nd, 0);

    // rst together with start: reset wins.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    @(negedge clk);
    chk("rst_start_idle", busy, 0);

    run_op(8'h0A, 8'h05, 1'b0, 1'b0, 9'h00F, 0, 1);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 0, 1);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF, 0, 1);
    run_op(8'h33, 8'h11, 1'b1, 1'b0, 9'h045, 0, 0);
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), 0, (i % 50) == 0);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("done_per_start", ndone, nacc);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It time-multiplexes a single 1-bit full-adder cell across WIDTH bit positions, adding two WIDTH-bit operands LSB-first, one bit per clock. It provides a start/busy/done handshake to the surrounding logic. It is the sequencing layer that turns the 1-bit full-adder datapath into a multi-bit adder without replicating the cell.

Parameters:
WIDTH, 8, operand/result width in bits (min 2)
CNT_W, $clog2(WIDTH+1), width of internal bit counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request: sample operands and begin addition
a  input  WIDTH  operand A, sampled only on accepted start
b  input  WIDTH  operand B, sampled only on accepted start
cin  input  1  carry-in, sampled only on accepted start
busy  output  1  high while addition in progress
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  final carry-out, held with sum

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on rising clk.
- Reset values:
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry FF and counter all cleared.
  - State=IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> accepted. Load shA<=a, shB<=b, carry<=cin, cnt<=0, go RUN.
  - start=0 -> stay IDLE. sum/cout keep their previous values.
- RUN (busy=1):
  - Each cycle the full-adder cell sees shA[0], shB[0], carry.
  - Its s output shifts into the result register from the MSB side (res<={s,res[WIDTH-1:1]}).
  - carry<=co; shA, shB shift right by 1; cnt<=cnt+1.
  - When cnt==WIDTH-1 on a RUN cycle, that is the last bit -> go DONE.
- DONE (1 cycle):
  - done=1, busy=0.
  - sum<=res and cout<=carry are registered on the transition into DONE, so they are valid while done=1.
  - Next state IDLE unconditionally.
- Latency: start accepted at edge k -> done=1 in the cycle after edge k+WIDTH. That is exactly WIDTH+1 edges from acceptance to the done edge.
- Throughput: one operation per WIDTH+2 cycles.
- Handshake rules:
  - start is ignored in RUN and DONE; no queuing.
  - a/b/cin may change freely after acceptance without affecting the result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, no overflow flag.
- Boundaries:
  - All-ones + 1 wraps sum to 0 with cout=1.
  - cin=1 with zero operands gives sum=1.
- Reset mid-RUN aborts immediately: next cycle is IDLE, outputs zeroed, no done pulse.
- rst and start asserted together: reset wins.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled with start.
  - sub=1 loads shB<=~b and carry<=1 (cin ignored), giving sum=a-b.
  - cout=1 means no borrow (a>=b).
  - sub=0 behaves exactly as the base block.
- Undefined: no sub port; add only.

Decomposition:
- Shared package serial_adder_pkg:
  - State enum/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- One natural sub-module: fa_bit, a combinational 1-bit full-adder cell (a, b, cin -> s, co), instantiated once inside the controller.
- Controller FSM, counter and shift registers stay in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start 1 cycle:
  - busy high for 8 cycles.
  - done pulse 9 edges after start edge.
  - sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=0, b=0, cin=1 -> sum=8'h01, cout=0.
- Re-assert start with a=8'h01, b=8'h01 at cycle 3 of a running op on 8'h10+8'h20:
  - Second start ignored.
  - Result sum=8'h30, cout=0.
  - busy never extends beyond 8 cycles.
- Assert rst at cycle 4 of RUN:
  - Next cycle busy=0, sum=0, cout=0.
  - No done pulse.
  - A fresh start afterwards computes correctly: 8'h0A+8'h05 -> 8'h0F.
- Random sweep, 1000 ops, random a/b/cin, checked against a reference model a+b+cin:
  - {cout,sum} match every op.
  - done exactly once per accepted start.
- With SERIAL_ADDER_SUB_EN, sub=1:
  - a=8'h10, b=8'h01 -> sum=8'h0F, cout=1.
  - a=8'h01, b=8'h02 -> sum=8'hFF, cout=0.
